// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
// Opcode/funct fields cover the supported subset: ld, sd, beq and R-type ALU ops.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_SD  = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic is_ld;
        logic is_sd;
        logic is_beq;
        logic is_r;
        logic legal;
    } inst_class_t;

endpackage

// File: rtl/inst_class_dec.sv
// Combinational instruction classifier: IR word to one-hot class plus a legal flag.
// Only opcode, funct3 and funct7 take part; register and immediate fields are ignored.
module inst_class_dec
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output inst_class_t cls
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_ld;
    logic       is_sd;
    logic       is_beq;
    logic       is_r;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign unused_fields = ^{instr[24:15], instr[11:7]};

    assign is_ld  = (opcode == OP_LOAD)   && (funct3 == F3_LD);
    assign is_sd  = (opcode == OP_STORE)  && (funct3 == F3_SD);
    assign is_beq = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);
    // R-type accepts any funct3; funct7 selects only the base/alternate ALU forms
    assign is_r   = (opcode == OP_OP) && ((funct7 == F7_BASE) || (funct7 == F7_ALT));

    assign cls = {is_ld, is_sd, is_beq, is_r, is_ld | is_sd | is_beq | is_r};

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main control FSM: sequences fetch/decode/exec/mem/wb and drives the
// datapath enables, memory handshakes, the sticky illegal flag and the retire counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic             alu_zero_i,
    input  logic             imem_rdy_i,
    input  logic             dmem_rdy_i,
    output logic             imem_req_o,
    output logic             ir_we_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_we_o,
    output logic             wb_sel_o,
    output logic             pc_we_o,
    output logic             pc_sel_o,
    output logic             illegal_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             illegal_q;
    logic [CNT_W-1:0] instret;
    inst_class_t      cls;

    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic       wb_sel;
    logic       pc_we;
    logic       pc_sel;
    logic       retire;

    inst_class_dec u_dec (
        .instr (instr_i),
        .cls   (cls)
    );

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        retire    = 1'b0;
        state_nxt = ST_FETCH;

        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy_i) begin
                    ir_we     = 1'b1;
                    state_nxt = ST_DECODE;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end

            ST_DECODE: begin
                state_nxt = cls.legal ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                if (cls.is_ld || cls.is_sd) begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_ADD;
                    state_nxt = ST_MEM;
                end else if (cls.is_r) begin
                    alu_op    = ALU_FUNCT;
                    state_nxt = ST_WB;
                end else if (cls.is_beq) begin
                    // Branch resolves and retires here; the taken decision is the ALU zero flag
                    alu_op    = ALU_SUB;
                    pc_we     = 1'b1;
                    pc_sel    = alu_zero_i;
                    retire    = 1'b1;
                    state_nxt = ST_FETCH;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end

            ST_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = cls.is_sd;
                alu_src_b = 1'b1;
                alu_op    = ALU_ADD;
                if (dmem_rdy_i) begin
                    if (cls.is_sd) begin
                        pc_we     = 1'b1;
                        retire    = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else begin
                    state_nxt = ST_MEM;
                end
            end

            ST_WB: begin
                // ALU controls stay as EXEC left them so the result stays stable during write
                reg_we    = 1'b1;
                wb_sel    = cls.is_ld;
                alu_src_b = cls.is_ld;
                alu_op    = cls.is_ld ? ALU_ADD : ALU_FUNCT;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_nxt = ST_FETCH;
            end

            ST_TRAP: begin
                state_nxt = ST_TRAP;
            end

            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            instret   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (retire) begin
                instret <= instret + CNT_ONE;
            end
            if ((state == ST_DECODE) && !cls.legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Reset masks every output immediately, so an access in flight is dropped this cycle
    assign imem_req_o  = rst_n & imem_req;
    assign ir_we_o     = rst_n & ir_we;
    assign dmem_req_o  = rst_n & dmem_req;
    assign dmem_we_o   = rst_n & dmem_we;
    assign alu_src_b_o = rst_n & alu_src_b;
    assign alu_op_o    = {2{rst_n}} & alu_op;
    assign reg_we_o    = rst_n & reg_we;
    assign wb_sel_o    = rst_n & wb_sel;
    assign pc_we_o     = rst_n & pc_we;
    assign pc_sel_o    = rst_n & pc_sel;
    assign illegal_o   = rst_n & illegal_q;
    assign state_o     = rst_n ? state : 3'd0;
    assign instret_o   = rst_n ? instret : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: an instruction-level model builds
// the expected per-cycle control trace and retire count for a 64-bit and a 4-bit counter.
module tb_multicycle_ctrl;

    localparam int K_LD  = 0;
    localparam int K_SD  = 1;
    localparam int K_BEQ = 2;
    localparam int K_R   = 3;
    localparam int K_ILL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] instr_i;
    logic        alu_zero_i;
    logic        imem_rdy_i;
    logic        dmem_rdy_i;

    logic        imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, alu_src_b_o;
    logic [1:0]  alu_op_o;
    logic        reg_we_o, wb_sel_o, pc_we_o, pc_sel_o, illegal_o;
    logic [2:0]  state_o;
    logic [63:0] instret_o;

    logic        unused_imem_req4, unused_ir_we4, unused_dmem_req4, unused_dmem_we4;
    logic        unused_alu_src_b4, unused_reg_we4, unused_wb_sel4, unused_pc_we4;
    logic        unused_pc_sel4, unused_illegal4;
    logic [1:0]  unused_alu_op4;
    logic [2:0]  unused_state4;
    logic [3:0]  instret4;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .alu_zero_i(alu_zero_i),
        .imem_rdy_i(imem_rdy_i), .dmem_rdy_i(dmem_rdy_i),
        .imem_req_o(imem_req_o), .ir_we_o(ir_we_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
        .illegal_o(illegal_o), .state_o(state_o), .instret_o(instret_o)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .alu_zero_i(alu_zero_i),
        .imem_rdy_i(imem_rdy_i), .dmem_rdy_i(dmem_rdy_i),
        .imem_req_o(unused_imem_req4), .ir_we_o(unused_ir_we4), .dmem_req_o(unused_dmem_req4),
        .dmem_we_o(unused_dmem_we4), .alu_src_b_o(unused_alu_src_b4), .alu_op_o(unused_alu_op4),
        .reg_we_o(unused_reg_we4), .wb_sel_o(unused_wb_sel4), .pc_we_o(unused_pc_we4),
        .pc_sel_o(unused_pc_sel4), .illegal_o(unused_illegal4), .state_o(unused_state4),
        .instret_o(instret4)
    );

    logic [14:0] obs;
    assign obs = {state_o, imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, alu_src_b_o,
                  alu_op_o, reg_we_o, wb_sel_o, pc_we_o, pc_sel_o, illegal_o};

    int              n_chk  = 0;
    int              n_pass = 0;
    longint unsigned ret64  = 0;
    int unsigned     ret4   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [14:0] ev(input logic [2:0] st, input logic imreq, input logic irwe,
                                       input logic dreq, input logic dwe, input logic srcb,
                                       input logic [1:0] op, input logic rwe, input logic wbs,
                                       input logic pcwe, input logic pcsel, input logic ill);
        return {st, imreq, irwe, dreq, dwe, srcb, op, rwe, wbs, pcwe, pcsel, ill};
    endfunction

    // One clock cycle: drive inputs, compare outputs and retire counts, then advance.
    task automatic step(input string tag, input logic irdy, input logic drdy, input logic az,
                        input logic [14:0] ex, input bit ret);
        imem_rdy_i = irdy;
        dmem_rdy_i = drdy;
        alu_zero_i = az;
        #1;
        check(tag, 64'(obs), 64'(ex));
        check({tag, "/instret"}, instret_o, ret64);
        check({tag, "/instret4"}, 64'(instret4), 64'(ret4));
        if (ret) begin
            ret64 = ret64 + 1;
            ret4  = (ret4 + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        imem_rdy_i = 1'b1;
        dmem_rdy_i = 1'b1;
        alu_zero_i = 1'b1;
        #1;
        check(tag, 64'(obs), 64'd0);
        check({tag, "/instret"}, instret_o, 64'd0);
        check({tag, "/instret4"}, 64'(instret4), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ret64 = 0;
        ret4  = 0;
    endtask

    function automatic logic [31:0] gen(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            K_LD:    begin r[6:0] = 7'b0000011; r[14:12] = 3'b011; end
            K_SD:    begin r[6:0] = 7'b0100011; r[14:12] = 3'b011; end
            K_BEQ:   begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
            default: begin r[6:0] = 7'b0110011; r[31:25] = rb() ? 7'b0100000 : 7'b0000000; end
        endcase
        return r;
    endfunction

    // Whole instruction; bz<0 randomizes alu_zero in EXEC; rst_mem resets during MEM stall.
    task automatic run_instr(input int kind, input logic [31:0] ins, input int fst,
                             input int mst, input int bz, input bit rst_mem);
        logic az;
        logic ld;
        logic sd;
        ld = (kind == K_LD);
        sd = (kind == K_SD);
        instr_i = ins;
        for (int i = 0; i < fst; i++)
            step("fetch_wait", 1'b0, rb(), rb(), ev(3'd0,1,0,0,0,0,2'b00,0,0,0,0,0), 0);
        step("fetch", 1'b1, rb(), rb(), ev(3'd0,1,1,0,0,0,2'b00,0,0,0,0,0), 0);
        step("decode", rb(), rb(), rb(), ev(3'd1,0,0,0,0,0,2'b00,0,0,0,0,0), 0);
        if (kind == K_ILL) return;
        if (ld || sd) begin
            step("exec_mem", rb(), rb(), rb(), ev(3'd2,0,0,0,0,1,2'b00,0,0,0,0,0), 0);
        end else if (kind == K_R) begin
            step("exec_r", rb(), rb(), rb(), ev(3'd2,0,0,0,0,0,2'b10,0,0,0,0,0), 0);
        end else begin
            az = (bz < 0) ? rb() : 1'(bz);
            step("exec_beq", rb(), rb(), az, ev(3'd2,0,0,0,0,0,2'b01,0,0,1,az,0), 1);
            return;
        end
        if (ld || sd) begin
            for (int i = 0; i < mst; i++) begin
                step("mem_wait", rb(), 1'b0, rb(), ev(3'd3,0,0,1,sd,1,2'b00,0,0,0,0,0), 0);
                if (rst_mem) begin
                    do_reset("rst_in_mem");
                    return;
                end
            end
            step("mem", rb(), 1'b1, rb(), ev(3'd3,0,0,1,sd,1,2'b00,0,0,sd,0,0), sd);
        end
        if (!sd)
            step("wb", rb(), rb(), rb(),
                 ev(3'd4,0,0,0,0,ld,(ld ? 2'b00 : 2'b10),1,ld,1,0,0), 1);
    endtask

    task automatic hold_trap(input int n);
        for (int i = 0; i < n; i++)
            step("trap", rb(), rb(), rb(), ev(3'd5,0,0,0,0,0,2'b00,0,0,0,0,1), 0);
    endtask

    initial begin
        int kind;
        rst_n      = 1'b0;
        instr_i    = 32'h0;
        alu_zero_i = 1'b0;
        imem_rdy_i = 1'b0;
        dmem_rdy_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        run_instr(K_LD,  32'h0000B183, 0, 0, -1, 0);
        run_instr(K_SD,  32'h0030B423, 0, 3, -1, 0);
        run_instr(K_BEQ, 32'h00208063, 0, 0,  1, 0);
        run_instr(K_BEQ, 32'h00208063, 0, 0,  0, 0);
        run_instr(K_R,   32'h002081B3, 0, 0, -1, 0);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            run_instr(kind, gen(kind), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), -1, 0);
        end

        run_instr(K_LD, gen(K_LD), 1, 2, -1, 1);
        run_instr(K_R, gen(K_R), 0, 0, -1, 0);

        run_instr(K_ILL, 32'hFFFFFFFF, 1, 0, -1, 0);
        hold_trap(4);
        do_reset("trap_rst");

        run_instr(K_SD, gen(K_SD), 0, 1, -1, 0);
        run_instr(K_ILL, 32'h0000A183, 0, 0, -1, 0);
        hold_trap(3);
        do_reset("trap_rst2");

        run_instr(K_BEQ, gen(K_BEQ), 2, 0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
